// File: rtl/mor1kx_rf_bypass_nport_pkg.sv
// Shared constants and types for the N-port register file with operand bypass.
package mor1kx_rf_bypass_nport_pkg;

   localparam int unsigned DEF_OPERAND_WIDTH = 32;
   localparam int unsigned DEF_RF_ADDR_WIDTH = 5;
   localparam int unsigned DEF_RF_WORDS      = 32;
   localparam int unsigned DEF_READ_PORTS    = 3;
   localparam int unsigned DEF_BYPASS_STAGES = 3;

   // Bypass source indices, youngest first
   localparam int unsigned STAGE_EXECUTE = 0;
   localparam int unsigned STAGE_CTRL    = 1;
   localparam int unsigned STAGE_WB      = 2;

   // Where a read port's operand comes from this cycle
   typedef enum logic [1:0] {
      SRC_STAGE  = 2'd0,
      SRC_WRPORT = 2'd1,
      SRC_RAM    = 2'd2,
      SRC_ZERO   = 2'd3
   } rf_src_e;

endpackage

// File: rtl/mor1kx_rf_bypass_nport_if.sv
// Decode/bypass/commit/scoreboard bundle between pipeline control and the RF.
interface mor1kx_rf_bypass_nport_if #(
   parameter int unsigned OPTION_OPERAND_WIDTH = mor1kx_rf_bypass_nport_pkg::DEF_OPERAND_WIDTH,
   parameter int unsigned OPTION_RF_ADDR_WIDTH = mor1kx_rf_bypass_nport_pkg::DEF_RF_ADDR_WIDTH,
   parameter int unsigned OPTION_RF_WORDS      = mor1kx_rf_bypass_nport_pkg::DEF_RF_WORDS,
   parameter int unsigned NUM_READ_PORTS       = mor1kx_rf_bypass_nport_pkg::DEF_READ_PORTS,
   parameter int unsigned NUM_BYPASS_STAGES    = mor1kx_rf_bypass_nport_pkg::DEF_BYPASS_STAGES
);
   localparam int unsigned W = OPTION_OPERAND_WIDTH;
   localparam int unsigned A = OPTION_RF_ADDR_WIDTH;
   localparam int unsigned N = NUM_READ_PORTS;
   localparam int unsigned S = NUM_BYPASS_STAGES;

   logic                       padv_decode_i;
   logic [N-1:0]               rd_en_i;
   logic [N*A-1:0]             rd_adr_i;
   logic [S-1:0]               stage_wb_i;
   logic [S*A-1:0]             stage_rfd_adr_i;
   logic [S-1:0]               stage_result_valid_i;
   logic [S*W-1:0]             stage_result_i;
   logic                       wr_en_i;
   logic [A-1:0]               wr_adr_i;
   logic [W-1:0]               wr_dat_i;
   logic                       issue_i;
   logic [A-1:0]               issue_adr_i;
   logic [N*W-1:0]             rd_dat_o;
   logic                       hazard_stall_o;
   logic [OPTION_RF_WORDS-1:0] pending_o;

   modport master (
      output padv_decode_i, rd_en_i, rd_adr_i,
      output stage_wb_i, stage_rfd_adr_i, stage_result_valid_i, stage_result_i,
      output wr_en_i, wr_adr_i, wr_dat_i, issue_i, issue_adr_i,
      input  rd_dat_o, hazard_stall_o, pending_o
   );

   modport slave (
      input  padv_decode_i, rd_en_i, rd_adr_i,
      input  stage_wb_i, stage_rfd_adr_i, stage_result_valid_i, stage_result_i,
      input  wr_en_i, wr_adr_i, wr_dat_i, issue_i, issue_adr_i,
      output rd_dat_o, hazard_stall_o, pending_o
   );

endinterface

// File: rtl/mor1kx_rf_bypass_nport_mux.sv
// One read port: youngest-first operand select over the pipeline stages,
// the commit write port and the RAM, plus the port's hazard flag.
module mor1kx_rf_bypass_mux
   import mor1kx_rf_bypass_nport_pkg::*;
#(
   parameter int unsigned OPTION_OPERAND_WIDTH = DEF_OPERAND_WIDTH,
   parameter int unsigned OPTION_RF_ADDR_WIDTH = DEF_RF_ADDR_WIDTH,
   parameter int unsigned NUM_BYPASS_STAGES    = DEF_BYPASS_STAGES,
   parameter int unsigned OPTION_RF_R0_ZERO    = 1
) (
   input  logic                                            en_i,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0]                 adr_i,
   input  logic [NUM_BYPASS_STAGES-1:0]                    stage_wb_i,
   input  logic [NUM_BYPASS_STAGES*OPTION_RF_ADDR_WIDTH-1:0] stage_rfd_adr_i,
   input  logic [NUM_BYPASS_STAGES-1:0]                    stage_result_valid_i,
   input  logic [NUM_BYPASS_STAGES*OPTION_OPERAND_WIDTH-1:0] stage_result_i,
   input  logic                                            wr_en_i,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0]                 wr_adr_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]                 wr_dat_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0]                 ram_dat_i,
   input  logic                                            pending_i,
   output logic [OPTION_OPERAND_WIDTH-1:0]                 dat_o,
   output logic                                            hazard_o
);
   localparam int unsigned W = OPTION_OPERAND_WIDTH;
   localparam int unsigned A = OPTION_RF_ADDR_WIDTH;
   localparam int unsigned S = NUM_BYPASS_STAGES;

   rf_src_e        src;
   logic           found;
   logic [W-1:0]   sel_dat;
   logic           sel_valid;

   // Priority select: first matching stage from the youngest, then write-through, then RAM
   always_comb begin
      found     = 1'b0;
      sel_dat   = '0;
      sel_valid = 1'b0;
      for (int unsigned k = STAGE_EXECUTE; k < S; k++) begin
         if (!found && stage_wb_i[k] && (stage_rfd_adr_i[k*A +: A] == adr_i)) begin
            found     = 1'b1;
            sel_dat   = stage_result_i[k*W +: W];
            sel_valid = stage_result_valid_i[k];
         end
      end

      if ((OPTION_RF_R0_ZERO != 0) && (adr_i == '0))
         src = SRC_ZERO;
      else if (found)
         src = SRC_STAGE;
      else if (wr_en_i && (wr_adr_i == adr_i))
         src = SRC_WRPORT;
      else
         src = SRC_RAM;

      case (src)
         SRC_STAGE:  dat_o = sel_dat;
         SRC_WRPORT: dat_o = wr_dat_i;
         SRC_RAM:    dat_o = ram_dat_i;
         default:    dat_o = '0;
      endcase

      // A RAM source only counts as a hazard when no younger producer exists,
      // so the pending bit is consulted only on that path.
      hazard_o = en_i && (((src == SRC_STAGE) && !sel_valid) ||
                          ((src == SRC_RAM) && pending_i));
   end

endmodule

// File: rtl/mor1kx_rf_bypass_nport.sv
// Register file with N bypassed decode read ports, long-latency scoreboard
// and execute-stage operand registers.
module mor1kx_rf_bypass_nport
   import mor1kx_rf_bypass_nport_pkg::*;
#(
   parameter int unsigned OPTION_OPERAND_WIDTH = DEF_OPERAND_WIDTH,
   parameter int unsigned OPTION_RF_ADDR_WIDTH = DEF_RF_ADDR_WIDTH,
   parameter int unsigned OPTION_RF_WORDS      = DEF_RF_WORDS,
   parameter int unsigned NUM_READ_PORTS       = DEF_READ_PORTS,
   parameter int unsigned NUM_BYPASS_STAGES    = DEF_BYPASS_STAGES,
   parameter int unsigned OPTION_RF_R0_ZERO    = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   mor1kx_rf_bypass_nport_if.slave   bus
);
   localparam int unsigned W     = OPTION_OPERAND_WIDTH;
   localparam int unsigned A     = OPTION_RF_ADDR_WIDTH;
   localparam int unsigned WORDS = OPTION_RF_WORDS;
   localparam int unsigned N     = NUM_READ_PORTS;

   logic [W-1:0]     mem [WORDS];
   logic [WORDS-1:0] pending_q, pending_d;
   logic [N*W-1:0]   rd_dat_q, rd_dat_d;
   logic [N*W-1:0]   port_dat;
   logic [N-1:0]     port_hazard;
   logic             wr_allowed;
   logic             issue_allowed;

   assign wr_allowed    = bus.wr_en_i && !((OPTION_RF_R0_ZERO != 0) && (bus.wr_adr_i == '0));
   assign issue_allowed = bus.issue_i && !((OPTION_RF_R0_ZERO != 0) && (bus.issue_adr_i == '0));

   // Commit write into the storage array (contents deliberately not reset)
   always_ff @(posedge clk) begin
      if (wr_allowed)
         mem[bus.wr_adr_i] <= bus.wr_dat_i;
   end

   for (genvar p = 0; p < N; p++) begin : g_port
      logic [A-1:0] adr;
      assign adr = bus.rd_adr_i[p*A +: A];

      mor1kx_rf_bypass_mux #(
         .OPTION_OPERAND_WIDTH (W),
         .OPTION_RF_ADDR_WIDTH (A),
         .NUM_BYPASS_STAGES    (NUM_BYPASS_STAGES),
         .OPTION_RF_R0_ZERO    (OPTION_RF_R0_ZERO)
      ) u_mux (
         .en_i                 (bus.rd_en_i[p]),
         .adr_i                (adr),
         .stage_wb_i           (bus.stage_wb_i),
         .stage_rfd_adr_i      (bus.stage_rfd_adr_i),
         .stage_result_valid_i (bus.stage_result_valid_i),
         .stage_result_i       (bus.stage_result_i),
         .wr_en_i              (bus.wr_en_i),
         .wr_adr_i             (bus.wr_adr_i),
         .wr_dat_i             (bus.wr_dat_i),
         .ram_dat_i            (mem[adr]),
         .pending_i            (pending_q[adr]),
         .dat_o                (port_dat[p*W +: W]),
         .hazard_o             (port_hazard[p])
      );
   end

   // Scoreboard next state: commit clears, issue sets, issue wins on a tie
   always_comb begin
      pending_d = pending_q;
      if (wr_allowed)
         pending_d[bus.wr_adr_i] = 1'b0;
      if (issue_allowed)
         pending_d[bus.issue_adr_i] = 1'b1;
   end

   // Operand capture: load resolved values on decode advance, else hold
   always_comb begin
      rd_dat_d = rd_dat_q;
      if (bus.padv_decode_i)
         rd_dat_d = port_dat;
   end

   // Scoreboard and operand registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q <= '0;
         rd_dat_q  <= '0;
      end else begin
         pending_q <= pending_d;
         rd_dat_q  <= rd_dat_d;
      end
   end

   assign bus.hazard_stall_o = |port_hazard;
   assign bus.rd_dat_o       = rd_dat_q;
   assign bus.pending_o      = pending_q;

endmodule

// File: tb/tb_mor1kx_rf_bypass_nport.sv
// Bench for mor1kx_rf_bypass_nport: directed scenarios plus random traffic
// against a per-cycle reference model of the register file and scoreboard.
module tb_mor1kx_rf_bypass_nport;
   import mor1kx_rf_bypass_nport_pkg::*;

   localparam int W = 32;
   localparam int A = 5;
   localparam int WORDS = 32;
   localparam int N = 3;
   localparam int S = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mor1kx_rf_bypass_nport_if #(
      .OPTION_OPERAND_WIDTH (W), .OPTION_RF_ADDR_WIDTH (A), .OPTION_RF_WORDS (WORDS),
      .NUM_READ_PORTS (N), .NUM_BYPASS_STAGES (S)
   ) bus ();

   mor1kx_rf_bypass_nport #(
      .OPTION_OPERAND_WIDTH (W), .OPTION_RF_ADDR_WIDTH (A), .OPTION_RF_WORDS (WORDS),
      .NUM_READ_PORTS (N), .NUM_BYPASS_STAGES (S), .OPTION_RF_R0_ZERO (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [W-1:0]     m_rf [WORDS];
   logic [WORDS-1:0] m_pend;
   logic [N*W-1:0]   m_op;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model of one read port: {hazard, operand}
   function automatic logic [W:0] resolve(input int p);
      logic [A-1:0] a;
      logic         en;
      a  = bus.rd_adr_i[p*A +: A];
      en = bus.rd_en_i[p];
      if (a == '0) return {1'b0, {W{1'b0}}};
      for (int k = 0; k < S; k++)
         if (bus.stage_wb_i[k] && bus.stage_rfd_adr_i[k*A +: A] == a)
            return {en & ~bus.stage_result_valid_i[k], bus.stage_result_i[k*W +: W]};
      if (bus.wr_en_i && bus.wr_adr_i == a) return {1'b0, bus.wr_dat_i};
      return {en & m_pend[a], m_rf[a]};
   endfunction

   function automatic logic model_stall();
      logic [W:0] r;
      logic st;
      st = 1'b0;
      for (int p = 0; p < N; p++) begin
         r  = resolve(p);
         st = st | r[W];
      end
      return st;
   endfunction

   task automatic idle();
      bus.padv_decode_i        = 1'b0;
      bus.rd_en_i              = '0;
      bus.rd_adr_i             = '0;
      bus.stage_wb_i           = '0;
      bus.stage_rfd_adr_i      = '0;
      bus.stage_result_valid_i = '0;
      bus.stage_result_i       = '0;
      bus.wr_en_i              = 1'b0;
      bus.wr_adr_i             = '0;
      bus.wr_dat_i             = '0;
      bus.issue_i              = 1'b0;
      bus.issue_adr_i          = '0;
   endtask

   // One clock: check the combinational stall, clock, update model, check state
   task automatic cycle();
      logic [N*W-1:0] res;
      logic [W:0]     r;
      logic           st;
      #1;
      st  = 1'b0;
      res = '0;
      for (int p = 0; p < N; p++) begin
         r = resolve(p);
         st = st | r[W];
         res[p*W +: W] = r[W-1:0];
      end
      chk("stall", 128'(bus.hazard_stall_o), 128'(st));
      if (bus.padv_decode_i) chk("padv_legal", 128'(bus.hazard_stall_o), 128'(1'b0));
      @(posedge clk);
      if (bus.padv_decode_i) m_op = res;
      if (bus.wr_en_i && bus.wr_adr_i != '0) begin
         m_rf[bus.wr_adr_i]   = bus.wr_dat_i;
         m_pend[bus.wr_adr_i] = 1'b0;
      end
      if (bus.issue_i && bus.issue_adr_i != '0) m_pend[bus.issue_adr_i] = 1'b1;
      #1;
      chk("rd_dat", 128'(bus.rd_dat_o), 128'(m_op));
      chk("pending", 128'(bus.pending_o), 128'(m_pend));
      @(negedge clk);
   endtask

   initial begin
      logic st;
      m_pend = '0;
      m_op   = '0;
      foreach (m_rf[i]) m_rf[i] = '0;
      idle();
      rst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset_rd_dat", 128'(bus.rd_dat_o), 128'(0));
      chk("reset_pending", 128'(bus.pending_o), 128'(0));
      chk("reset_stall", 128'(bus.hazard_stall_o), 128'(0));
      @(negedge clk);
      rst = 1'b1;

      // Give every register a known value
      for (int i = 1; i < WORDS; i++) begin
         idle();
         bus.wr_en_i  = 1'b1;
         bus.wr_adr_i = A'(i);
         bus.wr_dat_i = $urandom;
         cycle();
      end

      // Stage bypass: youngest matching stage wins
      idle();
      bus.stage_wb_i = 3'b011;
      bus.stage_rfd_adr_i[STAGE_EXECUTE*A +: A] = 5'd5;
      bus.stage_rfd_adr_i[STAGE_CTRL*A +: A]    = 5'd5;
      bus.stage_result_valid_i = 3'b111;
      bus.stage_result_i[STAGE_EXECUTE*W +: W] = 32'h11;
      bus.stage_result_i[STAGE_CTRL*W +: W]    = 32'h22;
      bus.rd_en_i = 3'b001;
      bus.rd_adr_i[0 +: A] = 5'd5;
      bus.padv_decode_i = 1'b1;
      #1 chk("bypass_nostall", 128'(bus.hazard_stall_o), 128'(0));
      cycle();
      chk("bypass_dat", 128'(bus.rd_dat_o[0 +: W]), 128'(32'h11));

      // Load-use: result not yet valid stalls, then resolves
      idle();
      bus.stage_wb_i = 3'b001;
      bus.stage_rfd_adr_i[STAGE_EXECUTE*A +: A] = 5'd7;
      bus.rd_en_i = 3'b010;
      bus.rd_adr_i[A +: A] = 5'd7;
      #1 chk("loaduse_stall", 128'(bus.hazard_stall_o), 128'(1));
      cycle();
      bus.stage_result_valid_i = 3'b001;
      bus.stage_result_i[STAGE_EXECUTE*W +: W] = 32'hCAFE;
      bus.padv_decode_i = 1'b1;
      #1 chk("loaduse_release", 128'(bus.hazard_stall_o), 128'(0));
      cycle();
      chk("loaduse_dat", 128'(bus.rd_dat_o[W +: W]), 128'(32'hCAFE));

      // Scoreboard: pending stalls, commit write-through releases same cycle
      idle();
      bus.issue_i = 1'b1;
      bus.issue_adr_i = 5'd9;
      cycle();
      chk("sb_set", 128'(bus.pending_o[9]), 128'(1));
      idle();
      bus.rd_en_i = 3'b001;
      bus.rd_adr_i[0 +: A] = 5'd9;
      #1 chk("sb_stall", 128'(bus.hazard_stall_o), 128'(1));
      cycle();
      bus.wr_en_i = 1'b1;
      bus.wr_adr_i = 5'd9;
      bus.wr_dat_i = 32'h1234;
      bus.padv_decode_i = 1'b1;
      #1 chk("sb_release", 128'(bus.hazard_stall_o), 128'(0));
      cycle();
      chk("sb_dat", 128'(bus.rd_dat_o[0 +: W]), 128'(32'h1234));
      chk("sb_clear", 128'(bus.pending_o[9]), 128'(0));

      // Simultaneous issue and commit: set wins
      idle();
      bus.issue_i = 1'b1;
      bus.issue_adr_i = 5'd3;
      bus.wr_en_i = 1'b1;
      bus.wr_adr_i = 5'd3;
      bus.wr_dat_i = 32'h5;
      cycle();
      chk("setclr_pending", 128'(bus.pending_o[3]), 128'(1));
      idle();
      bus.wr_en_i = 1'b1;
      bus.wr_adr_i = 5'd3;
      bus.wr_dat_i = 32'h6;
      cycle();

      // r0: writes, issues and stage producers are all ignored
      idle();
      bus.wr_en_i = 1'b1;
      bus.wr_adr_i = 5'd0;
      bus.wr_dat_i = 32'hFFFF;
      bus.issue_i = 1'b1;
      bus.issue_adr_i = 5'd0;
      cycle();
      idle();
      bus.rd_en_i = 3'b111;
      bus.stage_wb_i[STAGE_WB] = 1'b1;
      bus.stage_result_i[STAGE_WB*W +: W] = 32'h55;
      bus.padv_decode_i = 1'b1;
      #1 chk("r0_nostall", 128'(bus.hazard_stall_o), 128'(0));
      cycle();
      chk("r0_dat", 128'(bus.rd_dat_o), 128'(0));
      chk("r0_pending", 128'(bus.pending_o[0]), 128'(0));

      // Hold: a later write does not disturb a captured operand
      idle();
      bus.rd_en_i = 3'b100;
      bus.rd_adr_i[2*A +: A] = 5'd12;
      bus.wr_en_i = 1'b1;
      bus.wr_adr_i = 5'd12;
      bus.wr_dat_i = 32'hAA;
      bus.padv_decode_i = 1'b1;
      cycle();
      chk("hold_capture", 128'(bus.rd_dat_o[2*W +: W]), 128'(32'hAA));
      idle();
      bus.wr_en_i = 1'b1;
      bus.wr_adr_i = 5'd12;
      bus.wr_dat_i = 32'hBB;
      cycle();
      idle();
      cycle();
      chk("hold_keep", 128'(bus.rd_dat_o[2*W +: W]), 128'(32'hAA));

      // Random traffic on a narrow address range to force collisions
      for (int it = 0; it < 400; it++) begin
         bus.rd_en_i = N'($urandom);
         for (int p = 0; p < N; p++) bus.rd_adr_i[p*A +: A] = A'($urandom_range(0, 7));
         bus.stage_wb_i = S'($urandom);
         for (int k = 0; k < S; k++) begin
            bus.stage_rfd_adr_i[k*A +: A] = A'($urandom_range(0, 7));
            bus.stage_result_valid_i[k]   = ($urandom_range(0, 4) != 0);
            bus.stage_result_i[k*W +: W]  = $urandom;
         end
         bus.wr_en_i     = ($urandom_range(0, 1) != 0);
         bus.wr_adr_i    = A'($urandom_range(0, 7));
         bus.wr_dat_i    = $urandom;
         bus.issue_i     = ($urandom_range(0, 6) == 0);
         bus.issue_adr_i = A'($urandom_range(0, 7));
         st = model_stall();
         bus.padv_decode_i = !st && ($urandom_range(0, 1) != 0);
         cycle();
      end

      // Make sure state is non-trivial, then reset between clock edges
      idle();
      bus.rd_en_i = 3'b111;
      bus.rd_adr_i = {5'd14, 5'd13, 5'd12};
      bus.issue_i = 1'b1;
      bus.issue_adr_i = 5'd20;
      bus.padv_decode_i = !model_stall();
      cycle();
      idle();
      #2 rst = 1'b0;
      #1;
      chk("async_rst_rd_dat", 128'(bus.rd_dat_o), 128'(0));
      chk("async_rst_pending", 128'(bus.pending_o), 128'(0));
      chk("async_rst_stall", 128'(bus.hazard_stall_o), 128'(0));
      m_op   = '0;
      m_pend = '0;
      @(negedge clk);
      rst = 1'b1;
      cycle();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
